button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the three raw board push-buttons (left, right, shoot) before they reach the spaceship.
//  Sits between the FPGA pins and the spaceship block.
//  Stages: two-flop synchroniser -> per-button debounce -> output conditioning.
//  Left/right: debounced levels. Shoot: one-shot request, held until the next frame tick consumes it.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clk cycles an input must be stable before it is accepted (10 ms @ 25 MHz)
//  CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES-1
//  AUTOFIRE_FRAMES  11'd30  frames between repeated shots while shoot is held (AUTOFIRE_EN only)
// PORTS
//  clk            in   1   pixel clock
//  rst            in   1   synchronous, active-high reset
//  restart        in   1   game restart; clears shoot request and autofire state
//  mode           in   2   game mode; 2 = playing
//  xCoord         in   11  current VGA pixel x
//  yCoord         in   11  current VGA pixel y
//  btn_left_raw   in   1   asynchronous raw left button
//  btn_right_raw  in   1   asynchronous raw right button
//  btn_shoot_raw  in   1   asynchronous raw shoot button
//  button_left    out  1   debounced left, masked when right is also held
//  button_right   out  1   debounced right, masked when left is also held
//  button_shoot   out  1   pending shoot request, consumed at frame tick
//  shoot_stable   out  1   debounced shoot level (for scoreboard/debug)
// BEHAVIOUR
//  Reset values:
//   - On rst: all sync flops, stable levels, counters and outputs = 0.
//  frame_tick:
//   - frame_tick = (xCoord==0 && yCoord==0), combinational.
//   - Same definition the spaceship uses to sample its buttons.
//  Synchroniser:
//   - 2 flops per button. raw -> sync_q has 2-cycle latency.
//  Debounce (per button, independent):
//   - If sync_q == stable: cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync_q, cnt <= 0.
//   - Else: cnt <= cnt+1.
//   - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches stable.
//   - Total latency from raw edge to stable change: DEBOUNCE_CYCLES+2 cycles.
//  Left/right outputs (registered, 1 cycle after stable):
//   - button_left  <= stable_l & ~stable_r
//   - button_right <= stable_r & ~stable_l
//   - Both held -> both 0, so the ship does not move.
//  Shoot request (pending flag, drives button_shoot directly):
//   - set_evt = rising edge of stable_s (stable_s & ~stable_s_d).
//   - Priority, highest first:
//     1. rst, restart, or mode!=2 -> pending <= 0.
//     2. set_evt -> pending <= 1. A set in the same cycle as frame_tick wins; the request is not lost.
//     3. frame_tick -> pending <= 0. The flag is high during the tick cycle, so the spaceship samples it exactly once.
//   - Each press yields exactly one shot.
//   - A second press before consumption merges into the same request.
//   - Release has no effect on a pending request.
//  Reset mid-debounce:
//   - Counters cleared.
//   - A button still held after reset is re-accepted after DEBOUNCE_CYCLES+2 cycles.
//   - That re-acceptance produces a shoot edge.
// CONFIGURATION
//  Macro: BUTTON_CONDITIONER_AUTOFIRE_EN
//  Defined:
//   - 11-bit frame counter af_cnt; increments on frame_tick while stable_s=1 and mode==2.
//   - On reaching AUTOFIRE_FRAMES: af_cnt <= 0 and pending <= 1. Priority is the same as set_evt.
//   - af_cnt <= 0 on release, rst, restart, mode!=2, or a fresh press edge.
//  Undefined:
//   - No counter. Only press edges set pending.
//   - Holding shoot fires once.
// TESTING (DEBOUNCE_CYCLES=4, AUTOFIRE_FRAMES=3; frame_tick forced via xCoord/yCoord)
//  1. Left raw bounces 1-0-1 at 2-cycle spacing, then holds.
//     -> button_left stays 0 during the bounce; rises exactly 4+2+1 cycles after the final edge.
//  2. Left and right both held stable.
//     -> button_left=0, button_right=0. Release right -> button_left=1 after debounce+1 cycle.
//  3. Shoot pressed, held 10 frames, mode=2.
//     -> button_shoot high from the press until the first frame_tick cycle inclusive, then 0.
//     -> Without the macro: exactly one pulse.
//  4. Press edge reaches pending in the same cycle as frame_tick.
//     -> button_shoot=1 after that edge; consumed at the next tick; pulse count = 1.
//  5. Shoot pending, then restart=1 for 1 cycle (or mode=1).
//     -> button_shoot=0 next cycle; no shot on the following tick.
//     -> rst mid-debounce -> all outputs 0.
//  6. With BUTTON_CONDITIONER_AUTOFIRE_EN, hold shoot 10 frames.
//     -> Shots at the initial press, then every 3rd frame tick (4 total); release stops them.

Source files
------------

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the three raw board push-buttons (left, right, shoot) before
// they reach the spaceship block.
//   raw pin -> two-flop synchroniser -> per-button debounce -> conditioning
//
// Left/right leave as debounced levels, each masked while the other is held
// so the ship stays put when both are pressed. Shoot leaves as a one-shot
// request that is raised on a debounced press and held until the next frame
// tick (xCoord==0 && yCoord==0) consumes it.
//
// Optional feature (compile-time macro BUTTON_CONDITIONER_AUTOFIRE_EN):
//   while shoot is held in playing mode, a new request is raised every
//   AUTOFIRE_FRAMES frame ticks. Without the macro a held button fires once.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles an input must be stable before it is accepted
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//   AUTOFIRE_FRAMES  frame ticks between repeated shots (autofire only)
//
// Ports
//   clk            in   pixel clock
//   rst            in   synchronous, active-high reset
//   restart        in   game restart; clears shoot request / autofire state
//   mode     [1:0] in   game mode; 2 = playing
//   xCoord  [10:0] in   current VGA pixel x
//   yCoord  [10:0] in   current VGA pixel y
//   btn_*_raw      in   asynchronous raw buttons
//   button_left    out  debounced left, masked when right is also held
//   button_right   out  debounced right, masked when left is also held
//   button_shoot   out  pending shoot request, consumed at frame tick
//   shoot_stable   out  debounced shoot level
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          CNT_W           = 18,
    parameter logic [10:0] AUTOFIRE_FRAMES = 11'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [1:0]  mode,
    input  logic [10:0] xCoord,
    input  logic [10:0] yCoord,
    input  logic        btn_left_raw,
    input  logic        btn_right_raw,
    input  logic        btn_shoot_raw,
    output logic        button_left,
    output logic        button_right,
    output logic        button_shoot,
    output logic        shoot_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Configuration sanity checks, evaluated at elaboration.
    if (DEBOUNCE_CYCLES < 1 || longint'(CNT_LAST) != longint'(DEBOUNCE_CYCLES - 1)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (AUTOFIRE_FRAMES == 11'd0) begin : g_bad_af
        $error("AUTOFIRE_FRAMES must be non-zero");
    end

    // Bit order in all per-button vectors: [0]=left, [1]=right, [2]=shoot.
    logic [2:0]       raw;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       stable;
    logic [CNT_W-1:0] cnt [3];

    logic stable_s_d;
    logic pending;
    logic frame_tick;
    logic playing;
    logic set_evt;
    logic af_fire;

    assign raw        = {btn_shoot_raw, btn_right_raw, btn_left_raw};
    assign frame_tick = (xCoord == 11'd0) && (yCoord == 11'd0);
    assign playing    = (mode == 2'd2);
    assign set_evt    = stable[2] & ~stable_s_d;

    // ---- stage p0/p1: two-flop synchroniser --------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: accept a level only after it has held for the full count
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ---- output conditioning: left/right masking ---------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            button_left  <= 1'b0;
            button_right <= 1'b0;
        end else begin
            button_left  <= stable[0] & ~stable[1];
            button_right <= stable[1] & ~stable[0];
        end
    end

    // ---- output conditioning: shoot request --------------------------------
    // A set in the tick cycle beats the consume, so a press landing exactly on
    // the tick is delivered at the following tick instead of being dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_s_d <= 1'b0;
            pending    <= 1'b0;
        end else begin
            stable_s_d <= stable[2];
            if (restart || !playing) begin
                pending <= 1'b0;
            end else if (set_evt || af_fire) begin
                pending <= 1'b1;
            end else if (frame_tick) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOFIRE_EN
    logic [10:0] af_cnt;

    // Fires on the tick that completes AUTOFIRE_FRAMES held frames.
    assign af_fire = frame_tick && stable[2] && playing && !set_evt &&
                     (af_cnt == AUTOFIRE_FRAMES - 11'd1);

    always_ff @(posedge clk) begin
        if (rst || restart || !playing || !stable[2] || set_evt) begin
            af_cnt <= '0;
        end else if (frame_tick) begin
            af_cnt <= af_fire ? 11'd0 : af_cnt + 11'd1;
        end
    end
`else
    assign af_fire = 1'b0;
`endif

    assign button_shoot = pending;
    assign shoot_stable = stable[2];

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and
// AUTOFIRE_FRAMES=3. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point. Frame ticks are forced by driving xCoord/yCoord
// to zero for exactly one cycle.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic [1:0]  mode;
    logic [10:0] xCoord;
    logic [10:0] yCoord;
    logic        btn_left_raw;
    logic        btn_right_raw;
    logic        btn_shoot_raw;
    logic        button_left;
    logic        button_right;
    logic        button_shoot;
    logic        shoot_stable;

    int n_checks = 0;
    int n_errors = 0;
    int shots    = 0;

`ifdef BUTTON_CONDITIONER_AUTOFIRE_EN
    localparam int HELD_SHOTS = 3;  // fires at held ticks 3, 6, 9 -> seen at 4, 7, 10
`else
    localparam int HELD_SHOTS = 0;
`endif

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .AUTOFIRE_FRAMES (11'd3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .mode          (mode),
        .xCoord        (xCoord),
        .yCoord        (yCoord),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .btn_shoot_raw (btn_shoot_raw),
        .button_left   (button_left),
        .button_right  (button_right),
        .button_shoot  (button_shoot),
        .shoot_stable  (shoot_stable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: four idle cycles then a single tick cycle. A shot is what the
    // spaceship would see: button_shoot high during the tick cycle.
    task automatic frame();
        step(4);
        xCoord = 11'd0;
        yCoord = 11'd0;
        if (button_shoot) shots++;
        step(1);
        xCoord = 11'd5;
        yCoord = 11'd5;
    endtask

    initial begin
        rst           = 1'b1;
        restart       = 1'b0;
        mode          = 2'd2;
        xCoord        = 11'd5;
        yCoord        = 11'd5;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        btn_shoot_raw = 1'b0;

        // Reset state
        step(3);
        check("rst_left",   button_left,  0);
        check("rst_right",  button_right, 0);
        check("rst_shoot",  button_shoot, 0);
        check("rst_sstable", shoot_stable, 0);
        rst = 1'b0;
        step(2);

        // 1. Left bounce 1-0-1 at 2-cycle spacing, then hold
        btn_left_raw = 1'b1;
        for (int i = 0; i < 2; i++) begin step(); check("t1_bounce_hi", button_left, 0); end
        btn_left_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin step(); check("t1_bounce_lo", button_left, 0); end
        btn_left_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t1_left_rise", button_left, (i == 7));
        end

        // 2. Both held -> both masked; release right -> left returns
        btn_right_raw = 1'b1;
        step(9);
        check("t2_both_left",  button_left,  0);
        check("t2_both_right", button_right, 0);
        btn_right_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t2_left_back", button_left, (i == 7));
        end
        check("t2_right_off", button_right, 0);
        btn_left_raw = 1'b0;
        step(8);
        check("t2_left_off", button_left, 0);

        // 3. Shoot pressed and held: one request, consumed at first tick
        btn_shoot_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t3_set", button_shoot, (i == 7));
        end
        step(3);
        check("t3_hold", button_shoot, 1);
        xCoord = 11'd0;
        yCoord = 11'd0;
        check("t3_tick_cycle", button_shoot, 1);
        step();
        xCoord = 11'd5;
        yCoord = 11'd5;
        check("t3_consumed", button_shoot, 0);
        shots = 0;
        repeat (9) frame();
        check("t3_held_shots", shots, HELD_SHOTS);
        check("t3_sstable_held", shoot_stable, 1);
        btn_shoot_raw = 1'b0;
        step(8);
        check("t3_sstable_rel", shoot_stable, 0);
        shots = 0;
        repeat (3) frame();
        check("t3_after_release", shots, 0);

        // 4. Press edge reaches pending in the tick cycle
        btn_shoot_raw = 1'b1;
        step(6);
        xCoord = 11'd0;
        yCoord = 11'd0;
        check("t4_pre", button_shoot, 0);
        step();
        xCoord = 11'd5;
        yCoord = 11'd5;
        check("t4_set_wins", button_shoot, 1);
        shots = 0;
        frame();
        check("t4_pulses", shots, 1);
        check("t4_consumed", button_shoot, 0);
        btn_shoot_raw = 1'b0;
        step(8);

        // 5a. Restart cancels a pending request
        btn_shoot_raw = 1'b1;
        step(7);
        check("t5_pending", button_shoot, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t5_restart_clr", button_shoot, 0);
        shots = 0;
        frame();
        check("t5_restart_noshot", shots, 0);

        // 5b. Leaving playing mode cancels a pending request
        btn_shoot_raw = 1'b0;
        step(8);
        btn_shoot_raw = 1'b1;
        step(7);
        check("t5_pending2", button_shoot, 1);
        mode = 2'd1;
        step();
        mode = 2'd2;
        check("t5_mode_clr", button_shoot, 0);
        shots = 0;
        frame();
        check("t5_mode_noshot", shots, 0);

        // 5c. Reset mid-debounce, buttons still held -> re-accepted
        btn_left_raw = 1'b1;
        step(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_left",    button_left,  0);
        check("t5_rst_right",   button_right, 0);
        check("t5_rst_shoot",   button_shoot, 0);
        check("t5_rst_sstable", shoot_stable, 0);
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t5_reacc_sstable", shoot_stable, (i >= 6));
            check("t5_reacc_shoot",   button_shoot, (i == 7));
            check("t5_reacc_left",    button_left,  (i == 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
